// File: rtl/wb_bus_guard.sv
// wb_bus_guard: registered Wishbone classic bridge from the management-SoC
// port to the user_project peripheral bus. Every cycle is forwarded
// downstream; a cycle the slave never acks is answered with ERR_DATA after
// TIMEOUT_CYCLES, so the CPU cannot hang. Timeouts raise a sticky
// interrupt and bump a saturating counter.
module wb_bus_guard #(
  parameter int unsigned TIMEOUT_CYCLES = 255,  // 1 .. 2**CW-1
  parameter int unsigned CW             = 8,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  // upstream (master side)
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [3:0]  s_sel_i,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  output logic        s_ack_o,
  output logic [31:0] s_dat_o,
  // downstream (peripheral side)
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  // timeout reporting
  input  logic        err_clr_i,
  output logic        timeout_irq_o,
  output logic [7:0]  to_count_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Wait counter value during the last permitted BUSY cycle.
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          to_flag;
  logic          timeout;

  // A timeout fires on the edge ending the last BUSY cycle, unless the
  // master aborted or the slave acked in that same cycle (ack wins).
  assign timeout = (state == BUSY) && s_cyc_i && !m_ack_i &&
                   (wait_cnt == LAST_WAIT);

  assign timeout_irq_o = to_flag;

  // Bus FSM: capture the request, wait for ack or timeout, return one ack pulse.
  // NOTE: the request/response registers are reset along with the FSM so every
  // output is a known 0 out of reset; they are flops, not a memory array.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      s_ack_o  <= 1'b0;
      s_dat_o  <= '0;
      m_cyc_o  <= 1'b0;
      m_stb_o  <= 1'b0;
      m_we_o   <= 1'b0;
      m_sel_o  <= '0;
      m_adr_o  <= '0;
      m_dat_o  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values of state and wait_cnt regardless of statement order.
      case (state)
        IDLE: begin
          s_ack_o <= 1'b0;
          if (s_cyc_i && s_stb_i) begin
            m_we_o   <= s_we_i;
            m_sel_o  <= s_sel_i;
            m_adr_o  <= s_adr_i;
            m_dat_o  <= s_dat_i;
            m_cyc_o  <= 1'b1;
            m_stb_o  <= 1'b1;
            wait_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!s_cyc_i) begin
            // master abort: silently abandon the downstream cycle
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            state   <= IDLE;
          end else if (m_ack_i) begin
            s_dat_o <= m_dat_i;
            s_ack_o <= 1'b1;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            state   <= RESP;
          end else if (wait_cnt == LAST_WAIT) begin
            s_dat_o <= ERR_DATA;
            s_ack_o <= 1'b1;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          s_ack_o <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          s_ack_o <= 1'b0;
          m_cyc_o <= 1'b0;
          m_stb_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Sticky timeout flag: a set on the same edge as a clear takes priority.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      to_flag <= 1'b0;
    end else if (timeout) begin
      to_flag <= 1'b1;
    end else if (err_clr_i) begin
      to_flag <= 1'b0;
    end
  end

  // Saturating timeout counter, cleared only by reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      to_count_o <= '0;
    end else if (timeout && (to_count_o != 8'hFF)) begin
      to_count_o <= to_count_o + 8'd1;
    end
  end

endmodule
